// File: rtl/lp805x_syncunpack.sv
// Read-side consumer of the lp805x_syncg crossing: pops words with rrdy/rget and
// serialises them into a valid/ready byte stream, keeping one word prefetched.
module lp805x_syncunpack #(
  parameter int DATA_WIDTH = 40,
  parameter int BYTE_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rrdy,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rget,
  input  logic                  flush,
  output logic [BYTE_WIDTH-1:0] byte_out,
  output logic                  byte_vld,
  input  logic                  byte_rdy,
  output logic                  byte_last,
  output logic                  busy
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_GET   = 2'd1;
  localparam logic [1:0] F_GUARD = 2'd2;

  logic [1:0]            state;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift_data;
  logic [CNT_W-1:0]      cnt;
  logic                  capture;
  logic                  advance;
  logic                  shift_free;
  logic                  load_hold;
  logic                  load_direct;
  logic                  capture_to_hold;

  function automatic logic [BYTE_WIDTH-1:0] pick_byte(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [CNT_W-1:0] k);
    logic [BYTE_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == CNT_W'(i)) begin
        if (MSB_FIRST) r = d[DATA_WIDTH-1-i*BYTE_WIDTH -: BYTE_WIDTH];
        else           r = d[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return r;
  endfunction

  // The popped word goes straight into the shifter when it is free, otherwise it
  // waits in hold; this gives the two-cycle rrdy-to-first-byte latency.
  assign capture         = (state == F_GET);
  assign advance         = byte_vld & byte_rdy;
  assign shift_free      = ~byte_vld | (advance & (cnt == LAST_IDX));
  assign load_hold       = shift_free & hold_full;
  assign load_direct     = shift_free & ~hold_full & capture;
  assign capture_to_hold = capture & ~load_direct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= F_IDLE;
      rget  <= 1'b0;
    end else begin
      rget <= 1'b0;
      case (state)
        F_IDLE: begin
          if (rrdy && !hold_full) begin
            state <= F_GET;
            rget  <= 1'b1;
          end
        end
        F_GET:   state <= F_GUARD;
        F_GUARD: state <= F_IDLE;
        default: state <= F_IDLE;
      endcase
    end
  end

  // flush outranks load and advance; a word captured in the same cycle is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      byte_vld  <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      hold_full <= 1'b0;
      byte_vld  <= 1'b0;
      cnt       <= '0;
    end else begin
      hold_full <= capture_to_hold | (hold_full & ~load_hold);
      if (shift_free) begin
        byte_vld <= load_hold | load_direct;
        cnt      <= '0;
      end else if (advance) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture_to_hold) hold_data <= data_in;
    if (load_hold)        shift_data <= hold_data;
    else if (load_direct) shift_data <= data_in;
  end

  assign byte_out  = byte_vld ? pick_byte(shift_data, cnt) : '0;
  assign byte_last = byte_vld & (cnt == LAST_IDX);
  assign busy      = hold_full | byte_vld | (state != F_IDLE);

endmodule

// File: tb/tb_lp805x_syncunpack.sv
// Bench for lp805x_syncunpack: a syncg source model feeds two instances (MSB- and
// LSB-first) and a byte-list reference model predicts the delivered stream.
module tb_lp805x_syncunpack;
  localparam int DW = 40;
  localparam int BW = 8;
  localparam int NB = DW / BW;

  logic clk = 1'b0, rst = 1'b0, rrdy = 1'b0, flush = 1'b0, byte_rdy = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic rget, byte_vld, byte_last, busy;
  logic [BW-1:0] byte_out;
  logic rget_l, byte_vld_l, byte_last_l, busy_l;
  logic [BW-1:0] byte_out_l;

  int checks = 0, errors = 0;

  logic [DW-1:0] syncq[$];
  logic [16:0]   exp_q[$];
  logic [17:0]   got_q[$];
  logic [17:0]   want_q[$];
  bit pop_pend = 0, flush_pend = 0, prev_rget = 0, prev_stall = 0, rrdy_en = 1;
  logic [16:0] prev_obs = '0;
  int rdy_mode = 1, cyc = 0, rise_cyc = -1, first_rget = -1, first_vld = -1;
  int rget_cnt = 0, rget_adj = 0, stall_viol = 0, run = 0, max_run = 0, last_bad = 0;

  always #5 clk = ~clk;

  lp805x_syncunpack #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .rrdy(rrdy), .data_in(data_in), .rget(rget), .flush(flush),
    .byte_out(byte_out), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
    .byte_last(byte_last), .busy(busy));

  lp805x_syncunpack #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .rrdy(rrdy), .data_in(data_in), .rget(rget_l), .flush(flush),
    .byte_out(byte_out_l), .byte_vld(byte_vld_l), .byte_rdy(byte_rdy),
    .byte_last(byte_last_l), .busy(busy_l));

  // Source model, consumer and scoreboard; acts on the falling edge so every input
  // it drives is stable for the next rising edge.
  initial begin
    logic [DW-1:0] w;
    bit rrdy_n;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        w = syncq.pop_front();
        for (int k = 0; k < NB; k++)
          exp_q.push_back({(k == NB - 1), BW'(w >> (BW * (NB - 1 - k))), BW'(w >> (BW * k))});
        pop_pend = 0;
      end
      if (flush_pend) begin exp_q.delete(); flush_pend = 0; end
      if (!rst) begin exp_q.delete(); pop_pend = 0; flush_pend = 0; end
      case (rdy_mode)
        0: byte_rdy = 1'b0;
        1: byte_rdy = 1'b1;
        2: byte_rdy = ~byte_rdy;
        default: byte_rdy = 1'($urandom_range(0, 1));
      endcase
      rrdy_n = rrdy_en && (syncq.size() > 0);
      if (rrdy_n && !rrdy && rise_cyc < 0) rise_cyc = cyc;
      rrdy = rrdy_n;
      data_in = (syncq.size() > 0) ? syncq[0] : '0;
      if (rst && rget) begin
        pop_pend = 1;
        rget_cnt++;
        if (first_rget < 0) first_rget = cyc;
      end
      if (rget && prev_rget) rget_adj++;
      prev_rget = rget;
      if (rst && flush) flush_pend = 1;
      if (prev_stall && rst && !(byte_vld && ({byte_last, byte_out, byte_out_l} == prev_obs)))
        stall_viol++;
      if (byte_last && !byte_vld) last_bad++;
      if (byte_vld) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_vld < 0) first_vld = cyc;
      end else run = 0;
      if (byte_vld && byte_rdy) begin
        got_q.push_back({1'b0, byte_last, byte_out, byte_out_l});
        want_q.push_back((exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : {1'b1, 17'h0});
      end
      prev_stall = rst && byte_vld && !byte_rdy && !flush;
      prev_obs = {byte_last, byte_out, byte_out_l};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    got_q.delete(); want_q.delete();
    rget_cnt = 0; rget_adj = 0; stall_viol = 0; max_run = 0; run = 0; last_bad = 0;
    rise_cyc = -1; first_rget = -1; first_vld = -1;
  endtask

  task automatic wait_idle(input int maxc, output bit timeout);
    int quiet;
    quiet = 0;
    timeout = 1;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (syncq.size() == 0 && !pop_pend && !busy && !busy_l && !rrdy) quiet++;
      else quiet = 0;
      if (quiet >= 2) begin timeout = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 0; rdy_mode = 1; rrdy_en = 1;
    #100;
    checks++;
    if ({rget, byte_vld, byte_last, busy, byte_out} !== 12'h0) begin
      errors++; $display("FAIL reset_msb got %h want 000", {rget, byte_vld, byte_last, busy, byte_out});
    end
    checks++;
    if ({rget_l, byte_vld_l, byte_last_l, busy_l, byte_out_l} !== 12'h0) begin
      errors++; $display("FAIL reset_lsb got %h want 000", {rget_l, byte_vld_l, byte_last_l, busy_l, byte_out_l});
    end
    @(posedge clk); #2; rst = 1;
    tick(3);
    checks++;
    if ({rget, byte_vld, busy} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b want 000", {rget, byte_vld, busy});
    end
  endtask

  task automatic test_single();
    bit to;
    logic [7:0] lit [5];
    lit = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
    clear_obs(); rdy_mode = 1;
    syncq.push_back(40'hAA55);
    wait_idle(60, to);
    checks++; if (to) begin errors++; $display("FAIL t1_idle got timeout want idle"); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL t1_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t1_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][16:8] !== {(i == 4), lit[i]}) begin
        errors++; $display("FAIL t1_literal[%0d] got %h want %h", i, got_q[i][16:8], {(i == 4), lit[i]});
      end
    end
    checks++; if (rget_cnt != 1) begin errors++; $display("FAIL t1_rget_count got %0d want 1", rget_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got %b want 0", busy); end
    checks++; if (first_rget - rise_cyc != 1) begin errors++; $display("FAIL t1_rget_latency got %0d want 1", first_rget - rise_cyc); end
    checks++; if (first_vld - rise_cyc != 2) begin errors++; $display("FAIL t1_vld_latency got %0d want 2", first_vld - rise_cyc); end
  endtask

  task automatic test_stall();
    bit to;
    logic [7:0] lit [5];
    lit = '{8'hFF, 8'hFF, 8'h55, 8'h00, 8'h00};
    clear_obs(); rdy_mode = 2;
    syncq.push_back(40'hFF_FF55_0000);
    wait_idle(80, to);
    checks++; if (to) begin errors++; $display("FAIL t2_idle got timeout want idle"); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL t2_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][15:8] !== lit[i]) begin errors++; $display("FAIL t2_literal[%0d] got %h want %h", i, got_q[i][15:8], lit[i]); end
    end
    rdy_mode = 3;
    for (int i = 0; i < 3; i++) syncq.push_back(rand_word());
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL t2_rand_idle got timeout want idle"); end
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL t2_rand_count got %0d want 20", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t2_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL t2_stable got %0d changes want 0", stall_viol); end
    checks++; if (last_bad != 0) begin errors++; $display("FAIL t2_last_no_vld got %0d want 0", last_bad); end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_obs(); rdy_mode = 1;
    syncq.push_back(rand_word());
    syncq.push_back(rand_word());
    wait_idle(80, to);
    checks++; if (to) begin errors++; $display("FAIL t3_idle got timeout want idle"); end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL t3_count got %0d want 10", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t3_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    checks++; if (max_run != 10) begin errors++; $display("FAIL t3_no_bubble got %0d want 10", max_run); end
    checks++; if (rget_cnt != 2) begin errors++; $display("FAIL t3_rget_count got %0d want 2", rget_cnt); end
    checks++; if (rget_adj != 0) begin errors++; $display("FAIL t3_rget_adjacent got %0d want 0", rget_adj); end
  endtask

  task automatic test_lsb_first();
    bit to;
    logic [7:0] lit [5];
    lit = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    clear_obs(); rdy_mode = 1;
    syncq.push_back(40'h01_0203_0405);
    wait_idle(60, to);
    checks++; if (to) begin errors++; $display("FAIL t4_idle got timeout want idle"); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL t4_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][7:0] !== lit[i]) begin errors++; $display("FAIL t4_lsb[%0d] got %h want %h", i, got_q[i][7:0], lit[i]); end
      checks++;
      if (got_q[i][15:8] !== lit[4-i]) begin errors++; $display("FAIL t4_msb[%0d] got %h want %h", i, got_q[i][15:8], lit[4-i]); end
    end
  endtask

  task automatic test_flush();
    bit to, ok;
    logic [DW-1:0] c;
    clear_obs(); rdy_mode = 1;
    syncq.push_back(rand_word());
    syncq.push_back(rand_word());
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (got_q.size() >= 2) begin rdy_mode = 0; ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t5_wait_bytes got timeout want 2 bytes"); end
    tick(6);
    flush = 1; tick(1); flush = 0;
    checks++; if ({byte_vld, byte_vld_l, busy} !== 3'b000) begin
      errors++; $display("FAIL t5_after_flush got %b want 000", {byte_vld, byte_vld_l, busy});
    end
    c = rand_word();
    rdy_mode = 1;
    syncq.push_back(c);
    wait_idle(60, to);
    checks++; if (to) begin errors++; $display("FAIL t5_idle got timeout want idle"); end
    checks++; if (got_q.size() != 7) begin errors++; $display("FAIL t5_count got %0d want 7", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t5_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    if (got_q.size() > 2) begin
      checks++;
      if (got_q[2][15:8] !== BW'(c >> 32)) begin errors++; $display("FAIL t5_restart got %h want %h", got_q[2][15:8], BW'(c >> 32)); end
    end
    // flush landing on the capture edge must drop that word
    clear_obs();
    syncq.push_back(rand_word());
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rget) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t5_wait_rget got timeout want rget"); end
    flush = 1; tick(1); flush = 0;
    wait_idle(40, to);
    checks++; if (to) begin errors++; $display("FAIL t5_get_idle got timeout want idle"); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL t5_discard got %0d bytes want 0", got_q.size()); end
    checks++; if (rget_cnt != 1) begin errors++; $display("FAIL t5_discard_rget got %0d want 1", rget_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to, ok;
    int n;
    clear_obs(); rdy_mode = 1;
    syncq.push_back(rand_word());
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (got_q.size() >= 2) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t6_wait_bytes got timeout want 2 bytes"); end
    rrdy_en = 0;
    syncq.push_back(rand_word());
    rst = 0; #1;
    checks++;
    if ({rget, byte_vld, byte_last, busy, byte_out} !== 12'h0) begin
      errors++; $display("FAIL t6_async_clear got %h want 000", {rget, byte_vld, byte_last, busy, byte_out});
    end
    tick(2); rst = 1;
    n = rget_cnt;
    tick(6);
    checks++; if (rget_cnt != n) begin errors++; $display("FAIL t6_no_rget got %0d want %0d", rget_cnt, n); end
    rrdy_en = 1;
    wait_idle(60, to);
    checks++; if (to) begin errors++; $display("FAIL t6_idle got timeout want idle"); end
    checks++; if (got_q.size() != 7) begin errors++; $display("FAIL t6_count got %0d want 7", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t6_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    checks++; if (rget_cnt != n + 1) begin errors++; $display("FAIL t6_refetch got %0d want %0d", rget_cnt, n + 1); end
    clear_obs();
    syncq.push_back(rand_word());
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rget) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t6_wait_rget got timeout want rget"); end
    rst = 0; #1;
    checks++; if ({rget, busy} !== 2'b00) begin errors++; $display("FAIL t6_get_clear got %b want 00", {rget, busy}); end
    tick(2); rst = 1;
    wait_idle(60, to);
    checks++; if (to) begin errors++; $display("FAIL t6_get_idle got timeout want idle"); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL t6_get_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL t6_get_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    checks++; if (rget_cnt != 1) begin errors++; $display("FAIL t6_get_rget got %0d want 1", rget_cnt); end
  endtask

  task automatic test_random();
    bit to;
    clear_obs(); rdy_mode = 3;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if ($urandom_range(0, 3) == 0 && syncq.size() < 3) syncq.push_back(rand_word());
      flush = ($urandom_range(0, 39) == 0);
    end
    flush = 0;
    wait_idle(300, to);
    checks++; if (to) begin errors++; $display("FAIL tr_idle got timeout want idle"); end
    checks++; if (got_q.size() == 0) begin errors++; $display("FAIL tr_traffic got 0 bytes want >0"); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin errors++; $display("FAIL tr_stream[%0d] got %h want %h", i, got_q[i], want_q[i]); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL tr_stable got %0d changes want 0", stall_viol); end
    checks++; if (rget_adj != 0) begin errors++; $display("FAIL tr_rget_adjacent got %0d want 0", rget_adj); end
    checks++; if (last_bad != 0) begin errors++; $display("FAIL tr_last_no_vld got %0d want 0", last_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_lsb_first();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
